pipe_sel_mux: RTL and testbench

- Parametrised N-channel, W-bit registered multiplexer with valid/ready handshake on both sides.
- Successor of the 2-input 1-bit address-selected mux.
- Sits in the RV32IM datapath wherever a registered operand/forwarding select must tolerate downstream stalls without losing data.
- Internal 2-entry skid buffer gives full throughput and a registered in_ready.

---
 rtl/pipe_sel_mux.sv | 127 ++++++++++++
 tb/tb_pipe_sel_mux.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_sel_mux.sv
// N-channel W-bit registered select mux with valid/ready on both sides and a 2-entry skid buffer.
// Define PIPE_SEL_MUX_ERRCNT_EN to add a saturating err_count output for out-of-range beats.
module pipe_sel_mux #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [WIDTH*CHANNELS-1:0] in_data,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_err,
  output logic                      out_valid,
  input  logic                      out_ready
`ifdef PIPE_SEL_MUX_ERRCNT_EN
  ,
  output logic [15:0]               err_count
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   main_data_q;
  logic               main_err_q;
  logic [WIDTH-1:0]   skid_data_q;
  logic               skid_err_q;
  logic               in_ready_q;
  logic               out_valid_q;

  logic [WIDTH-1:0]   cap_data_d;
  logic               cap_err_d;
  logic               in_fire;
  logic               out_fire;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_data_q;
  assign out_err   = main_err_q;

  // An unmatched select leaves data zero and flags the beat as erroneous.
  always_comb begin
    cap_data_d = '0;
    cap_err_d  = 1'b1;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (in_sel == SEL_W'(k)) begin
        cap_data_d = in_data[k*WIDTH +: WIDTH];
        cap_err_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_err_q  <= 1'b0;
      skid_data_q <= '0;
      skid_err_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_data_q <= cap_data_d;
            main_err_q  <= cap_err_d;
            out_valid_q <= 1'b1;
            state_q     <= ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_data_q <= cap_data_d;
            main_err_q  <= cap_err_d;
          end else if (in_fire) begin
            skid_data_q <= cap_data_d;
            skid_err_q  <= cap_err_d;
            in_ready_q  <= 1'b0;
            state_q     <= FULL;
          end else if (out_fire) begin
            out_valid_q <= 1'b0;
            state_q     <= EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_data_q <= skid_data_q;
            main_err_q  <= skid_err_q;
            in_ready_q  <= 1'b1;
            state_q     <= ONE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= EMPTY;
        end
      endcase
    end
  end

`ifdef PIPE_SEL_MUX_ERRCNT_EN
  logic [15:0] err_count_q;

  assign err_count = err_count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_count_q <= '0;
    end else if (out_fire && main_err_q && (err_count_q != '1)) begin
      err_count_q <= err_count_q + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_sel_mux.sv
// Scoreboard bench for pipe_sel_mux: 4-channel instance for throughput/ordering, 3-channel for out-of-range.
module tb_pipe_sel_mux;

  logic         clk;
  logic         reset_n;

  logic [31:0]  ch [4];
  logic [127:0] in_data;
  logic [1:0]   in_sel;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  out_data;
  logic         out_err;
  logic         out_valid;
  logic         out_ready;

  logic [31:0]  ch3 [3];
  logic [95:0]  in_data3;
  logic [1:0]   in_sel3;
  logic         in_valid3;
  logic         in_ready3;
  logic [31:0]  out_data3;
  logic         out_err3;
  logic         out_valid3;
  logic         out_ready3;
`ifdef PIPE_SEL_MUX_ERRCNT_EN
  logic [15:0]  err_count;
  logic [15:0]  err_count3;
`endif

  int total = 0;
  int bad   = 0;
  int n_push = 0;
  int n_pop  = 0;

  typedef struct {
    logic [31:0] d;
    logic        e;
  } exp_t;
  exp_t sb [$];

  logic        hold_v;
  logic [31:0] hold_d;
  logic        hold_e;

  assign in_data  = {ch[3], ch[2], ch[1], ch[0]};
  assign in_data3 = {ch3[2], ch3[1], ch3[0]};

  pipe_sel_mux #(.WIDTH(32), .CHANNELS(4)) u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef PIPE_SEL_MUX_ERRCNT_EN
    ,
    .err_count (err_count)
`endif
  );

  pipe_sel_mux #(.WIDTH(32), .CHANNELS(3)) u_dut3 (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_data   (in_data3),
    .in_sel    (in_sel3),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .out_data  (out_data3),
    .out_err   (out_err3),
    .out_valid (out_valid3),
    .out_ready (out_ready3)
`ifdef PIPE_SEL_MUX_ERRCNT_EN
    ,
    .err_count (err_count3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model4(input logic [1:0] s);
    exp_t r;
    if (int'(s) < 4) begin
      r.d = ch[s];
      r.e = 1'b0;
    end else begin
      r.d = '0;
      r.e = 1'b1;
    end
    return r;
  endfunction

  // Scoreboard and hold-stability monitor for the 4-channel instance.
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        check_eq("hold_data", 64'(out_data), 64'(hold_d));
        check_eq("hold_err", 64'(out_err), 64'(hold_e));
      end
      hold_v = out_valid && !out_ready;
      hold_d = out_data;
      hold_e = out_err;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check_eq("sb_underflow", 64'(sb.size()), 64'(1));
        end else begin
          e = sb.pop_front();
          check_eq("sb_data", 64'(out_data), 64'(e.d));
          check_eq("sb_err", 64'(out_err), 64'(e.e));
          n_pop++;
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(model4(in_sel));
        n_push++;
      end
    end
  end

  task automatic drive_beat(input int n);
    logic [1:0] s;
    s = 2'(n % 4);
    for (int k = 0; k < 4; k++) ch[k] = $urandom;
    ch[s]    = 32'h0001_0000 + 32'(n);
    in_sel   = s;
    in_valid = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int cyc;
    int pop0;
    logic acc;

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_sel    = '0;
    out_ready = 1'b1;
    in_valid3 = 1'b0;
    in_sel3   = '0;
    out_ready3 = 1'b1;
    for (int k = 0; k < 4; k++) ch[k] = '0;
    ch3[0] = 32'hAAAA_0000;
    ch3[1] = 32'hBBBB_1111;
    ch3[2] = 32'hCCCC_2222;
    hold_v = 1'b0;

    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_out_valid", 64'(out_valid), 64'(0));
    check_eq("rst_out_data", 64'(out_data), 64'(0));
    check_eq("rst_out_err", 64'(out_err), 64'(0));
    check_eq("rst_in_ready", 64'(in_ready), 64'(1));

    // Basic select: one beat per cycle, each visible one cycle after acceptance.
    ch[0] = 32'h1111_1111; ch[1] = 32'h2222_2222;
    ch[2] = 32'h3333_3333; ch[3] = 32'h4444_4444;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_sel = 2'(i);
      check_eq("basic_in_ready", 64'(in_ready), 64'(1));
      @(posedge clk); #1;
      check_eq("basic_valid", 64'(out_valid), 64'(1));
      check_eq("basic_data", 64'(out_data), 64'(32'h1111_1111 * (i + 1)));
      check_eq("basic_err", 64'(out_err), 64'(0));
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check_eq("basic_drained", 64'(out_valid), 64'(0));

    // Out-of-range select on the 3-channel instance, then an in-range beat.
    in_sel3 = 2'd3; in_valid3 = 1'b1;
    @(posedge clk); #1;
    check_eq("oor_valid", 64'(out_valid3), 64'(1));
    check_eq("oor_data", 64'(out_data3), 64'(0));
    check_eq("oor_err", 64'(out_err3), 64'(1));
    in_sel3 = 2'd2;
    @(posedge clk); #1;
    in_valid3 = 1'b0;
`ifdef PIPE_SEL_MUX_ERRCNT_EN
    check_eq("oor_errcnt", 64'(err_count3), 64'(1));
`endif
    check_eq("ch2_data", 64'(out_data3), 64'(32'hCCCC_2222));
    check_eq("ch2_err", 64'(out_err3), 64'(0));
    @(posedge clk); #1;
    check_eq("oor_drained", 64'(out_valid3), 64'(0));
`ifdef PIPE_SEL_MUX_ERRCNT_EN
    check_eq("errcnt_no_inc", 64'(err_count3), 64'(1));
`endif

    // Backpressure: A held on the output, B parked in the skid.
    out_ready = 1'b0;
    in_valid = 1'b1; in_sel = 2'd1;
    @(posedge clk); #1;
    check_eq("bp_a_data", 64'(out_data), 64'(32'h2222_2222));
    check_eq("bp_rdy_one", 64'(in_ready), 64'(1));
    in_sel = 2'd2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("bp_full_rdy", 64'(in_ready), 64'(0));
    check_eq("bp_a_hold", 64'(out_data), 64'(32'h2222_2222));
    @(posedge clk); #1;
    check_eq("bp_a_hold2", 64'(out_data), 64'(32'h2222_2222));
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("bp_b_data", 64'(out_data), 64'(32'h3333_3333));
    check_eq("bp_b_valid", 64'(out_valid), 64'(1));
    check_eq("bp_rdy_back", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    check_eq("bp_drained", 64'(out_valid), 64'(0));

    // Full-rate random stall/release with counting data.
    pop0 = n_pop;
    n = 0;
    cyc = 0;
    drive_beat(0);
    out_ready = 1'($urandom_range(0, 1));
    while (n < 200 && cyc < 5000) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) n++;
      if (n < 200) begin
        if (acc) drive_beat(n);
      end else begin
        in_valid = 1'b0;
      end
      out_ready = 1'($urandom_range(0, 1));
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && sb.size() != 0; c++) begin
      @(posedge clk); #1;
    end
    check_eq("rand_accepts", 64'(n), 64'(200));
    check_eq("rand_sb_empty", 64'(sb.size()), 64'(0));
    check_eq("rand_delivered", 64'(n_pop - pop0), 64'(200));

    // Asynchronous reset while FULL.
    out_ready = 1'b0;
    in_valid = 1'b1; in_sel = 2'd0;
    @(posedge clk); #1;
    in_sel = 2'd1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("mid_full_rdy", 64'(in_ready), 64'(0));
    #2 reset_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", 64'(out_valid), 64'(0));
    check_eq("mid_rst_rdy", 64'(in_ready), 64'(1));
    check_eq("mid_rst_data", 64'(out_data), 64'(0));
    sb.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    out_ready = 1'b1;
    ch[3] = 32'h5A5A_A5A5;
    in_valid = 1'b1; in_sel = 2'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("post_rst_data", 64'(out_data), 64'(32'h5A5A_A5A5));
    @(posedge clk); #1;
    check_eq("post_rst_drained", 64'(out_valid), 64'(0));

`ifdef PIPE_SEL_MUX_ERRCNT_EN
    check_eq("errcnt4_zero", 64'(err_count), 64'(0));
    in_sel3 = 2'd3; in_valid3 = 1'b1; out_ready3 = 1'b1;
    repeat (65540) @(posedge clk);
    #1 in_valid3 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("errcnt_sat", 64'(err_count3), 64'(16'hFFFF));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
